// File: rtl/prbs_checker_pkg.sv
// Shared types and constants for the 10-bit PRBS checker (x[n] = x[n-10] ^ x[n-7]).
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 9;
  localparam int TAP_B  = 6;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit stream and status bundle for prbs_checker.
// PRBS_CHK_BITCNT_EN adds the locked-bit counter to the bundle.
interface prbs_checker_if #(
  parameter int ERR_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       lost_cnt;
  logic             stuck_zero;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_count;

  modport master (output bit_in, bit_valid, clear,
                  input  locked, err_pulse, err_count, lost_cnt, stuck_zero, bit_count);
  modport slave  (input  bit_in, bit_valid, clear,
                  output locked, err_pulse, err_count, lost_cnt, stuck_zero, bit_count);
`else
  modport master (output bit_in, bit_valid, clear,
                  input  locked, err_pulse, err_count, lost_cnt, stuck_zero);
  modport slave  (input  bit_in, bit_valid, clear,
                  output locked, err_pulse, err_count, lost_cnt, stuck_zero);
`endif
endinterface

// File: rtl/prbs_checker_predictor.sv
// History shift register of received bits and the next-bit prediction it implies.
module prbs_predictor
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [LFSR_W-1:0] hist,
  output logic              predicted,
  output logic              zero
);

  logic [LFSR_W-1:0] r_hist;

  // hist[0] is the newest bit; the stream itself seeds the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else if (shift_en) begin
      r_hist <= {r_hist[LFSR_W-2:0], bit_in};
    end
  end

  assign hist      = r_hist;
  assign predicted = r_hist[TAP_A] ^ r_hist[TAP_B];
  assign zero      = (r_hist == '0);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 10-bit LFSR stream: lock FSM, error and loss counters.
// Optional PRBS_CHK_BITCNT_EN adds a saturating count of bits checked while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input logic           clk,
  input logic           rst,
  prbs_checker_if.slave bus
);

  localparam logic [3:0]  FILL_LAST = 4'(LFSR_W - 1);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [10:0] WIN_LAST  = 11'(WINDOW - 1);
  localparam logic [10:0] LOSS_LAST = 11'(LOSS_THRESH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_fill_cnt;
  logic [7:0]        r_match_cnt;
  logic [10:0]       r_win_cnt;
  logic [10:0]       r_win_err;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;
  logic [7:0]        r_lost_cnt;
  logic              r_stuck_zero;

  logic [LFSR_W-1:0] w_hist;
  logic              w_predicted;
  logic              w_zero;
  logic              w_mismatch;
  logic              w_fill_done;
  logic              w_lock_hit;
  logic              w_err_locked;
  logic              w_loss;
  logic              w_win_end;
  logic              w_locked;

  prbs_predictor u_pred (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (bus.bit_valid),
    .bit_in    (bus.bit_in),
    .hist      (w_hist),
    .predicted (w_predicted),
    .zero      (w_zero)
  );

  assign w_mismatch   = w_predicted ^ bus.bit_in;
  assign w_fill_done  = bus.bit_valid && (r_state == FILL) && (r_fill_cnt == FILL_LAST);
  assign w_lock_hit   = bus.bit_valid && (r_state == VERIFY) && !w_zero && !w_mismatch &&
                        (r_match_cnt == LOCK_LAST);
  assign w_err_locked = bus.bit_valid && (r_state == LOCKED) && w_mismatch;
  assign w_loss       = w_err_locked && (r_win_err == LOSS_LAST);
  assign w_win_end    = bus.bit_valid && (r_state == LOCKED) && !w_loss && (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fill_done) w_state_nxt = VERIFY;
      VERIFY:  if (w_lock_hit)  w_state_nxt = LOCKED;
      LOCKED:  if (w_loss)      w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_locked = (r_state == LOCKED);
  end

  // Acquisition counters: fill length, then a run of correct predictions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
    end else begin
      if (w_loss || w_fill_done) begin
        r_fill_cnt <= '0;
      end else if (bus.bit_valid && (r_state == FILL)) begin
        r_fill_cnt <= r_fill_cnt + 4'd1;
      end

      if (w_fill_done || w_lock_hit) begin
        r_match_cnt <= '0;
      end else if (bus.bit_valid && (r_state == VERIFY)) begin
        r_match_cnt <= (w_zero || w_mismatch) ? 8'd0 : r_match_cnt + 8'd1;
      end
    end
  end

  // Loss-of-lock window: errors only accumulate within one WINDOW of checked bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (w_loss || w_win_end) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (bus.bit_valid && (r_state == LOCKED)) begin
      r_win_cnt <= r_win_cnt + 11'd1;
      r_win_err <= r_win_err + {10'd0, w_mismatch};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_lost_cnt   <= '0;
      r_stuck_zero <= 1'b0;
    end else begin
      r_err_pulse  <= w_err_locked;
      r_stuck_zero <= (w_hist == '0);
      if (bus.clear) begin
        r_err_count <= '0;
        r_lost_cnt  <= '0;
      end else begin
        if (w_err_locked) r_err_count <= ERR_W'(sat_inc(32'(r_err_count), ERR_W));
        if (w_loss)       r_lost_cnt  <= 8'(sat_inc(32'(r_lost_cnt), 8));
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] r_bit_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_count <= '0;
    end else if (bus.clear) begin
      r_bit_count <= '0;
    end else if (bus.bit_valid && (r_state == LOCKED)) begin
      r_bit_count <= sat_inc(r_bit_count, 32);
    end
  end

  assign bus.bit_count = r_bit_count;
`endif

  assign bus.locked     = w_locked;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_count  = r_err_count;
  assign bus.lost_cnt   = r_lost_cnt;
  assign bus.stuck_zero = r_stuck_zero;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: reference LFSR source with injectable bit inversions.
// Expected err_pulse per bit is queued from the injected error pattern and checked one cycle later.
module tb_prbs_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [9:0]  gen;
  logic [10:0] eh;
  logic        exp_lock;
  logic        exp_q[$];

  prbs_checker_if #(.ERR_W(16)) bus ();

  prbs_checker #(
    .LOCK_CNT    (16),
    .WINDOW      (64),
    .LOSS_THRESH (4),
    .ERR_W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst           = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clear     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_stream();
    gen      = 10'b0000000001;
    eh       = '0;
    exp_lock = 1'b0;
    exp_q.delete();
  endtask

  // One valid bit from the generator, optionally inverted; expected err_pulse queued now, checked after the edge.
  task automatic send(input logic inv, input logic clr);
    logic nb;
    logic mism;
    logic exp_e;
    nb   = gen[9] ^ gen[6];
    gen  = {gen[8:0], nb};
    eh   = {eh[9:0], inv};
    mism = eh[0] ^ eh[7] ^ eh[10];
    exp_q.push_back(exp_lock & mism);
    @(negedge clk);
    bus.bit_in    = nb ^ inv;
    bus.bit_valid = 1'b1;
    bus.clear     = clr;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    bus.clear     = 1'b0;
    exp_e = exp_q.pop_front();
    checks++;
    if (bus.err_pulse !== exp_e) begin
      errors++;
      $display("FAIL err_pulse got %b want %b", bus.err_pulse, exp_e);
    end
  endtask

  task automatic idle();
    logic exp_e;
    exp_q.push_back(1'b0);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.bit_in    = $urandom_range(1, 0);
    @(posedge clk);
    #1;
    exp_e = exp_q.pop_front();
    checks++;
    if (bus.err_pulse !== exp_e) begin
      errors++;
      $display("FAIL idle_err_pulse got %b want %b", bus.err_pulse, exp_e);
    end
  endtask

  task automatic lock_up(input string tag);
    for (int n = 1; n <= 26; n++) send(1'b0, 1'b0);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock got %b want 1", tag, bus.locked);
    end
    exp_lock = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clear     = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.locked, bus.err_pulse, bus.stuck_zero, bus.err_count, bus.lost_cnt} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got lk=%b ep=%b sz=%b ec=%0d lc=%0d want all 0",
               bus.locked, bus.err_pulse, bus.stuck_zero, bus.err_count, bus.lost_cnt);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    start_stream();
    for (int n = 1; n <= 30; n++) begin
      send(1'b0, 1'b0);
      checks++;
      if (bus.locked !== (n >= 26)) begin
        errors++;
        $display("FAIL clean_locked bit %0d got %b want %b", n, bus.locked, (n >= 26));
      end
    end
    checks++;
    if (bus.err_count !== 16'd0 || bus.lost_cnt !== 8'd0 || bus.stuck_zero !== 1'b0) begin
      errors++;
      $display("FAIL clean_counters got ec=%0d lc=%0d sz=%b want 0 0 0",
               bus.err_count, bus.lost_cnt, bus.stuck_zero);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    start_stream();
    lock_up("single");
    // Second inversion lands in the next 64-bit window, so six errors never lose lock.
    for (int i = 0; i < 100; i++) begin
      send(i == 5 || i == 70, 1'b0);
      if (i == 5) begin
        checks++;
        if (bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin
          errors++;
          $display("FAIL single_first got ec=%0d lk=%b want 1 1", bus.err_count, bus.locked);
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.err_count !== 16'd3) begin
          errors++;
          $display("FAIL single_three got ec=%0d want 3", bus.err_count);
        end
      end
    end
    checks++;
    if (bus.err_count !== 16'd6 || bus.locked !== 1'b1 || bus.lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL single_window got ec=%0d lk=%b lc=%0d want 6 1 0",
               bus.err_count, bus.locked, bus.lost_cnt);
    end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    start_stream();
    lock_up("loss");
    for (int i = 0; i < 36; i++) send(i == 5 || i == 35, 1'b0);
    exp_lock = 1'b0;
    checks++;
    if (bus.locked !== 1'b0 || bus.lost_cnt !== 8'd1 || bus.err_count !== 16'd4) begin
      errors++;
      $display("FAIL loss_state got lk=%b lc=%0d ec=%0d want 0 1 4",
               bus.locked, bus.lost_cnt, bus.err_count);
    end
    for (int n = 1; n <= 26; n++) begin
      send(1'b0, 1'b0);
      if (n == 25 || n == 26) begin
        checks++;
        if (bus.locked !== (n == 26)) begin
          errors++;
          $display("FAIL relock bit %0d got %b want %b", n, bus.locked, (n == 26));
        end
      end
    end
    exp_lock = 1'b1;
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    checks++;
    if (bus.lost_cnt !== 8'd0 || bus.err_count !== 16'd0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_clear got lc=%0d ec=%0d lk=%b want 0 0 1",
               bus.lost_cnt, bus.err_count, bus.locked);
    end
  endtask

  task automatic test_gapped_valid();
    do_reset();
    start_stream();
    for (int n = 1; n <= 26; n++) begin
      idle();
      idle();
      send(1'b0, 1'b0);
      if (n == 25 || n == 26) begin
        checks++;
        if (bus.locked !== (n == 26)) begin
          errors++;
          $display("FAIL gapped_lock bit %0d got %b want %b", n, bus.locked, (n == 26));
        end
      end
    end
    idle();
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 16'd0) begin
      errors++;
      $display("FAIL gapped_hold got lk=%b ec=%0d want 1 0", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_stuck_zero();
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.bit_valid = 1'b0;
      if (n >= 11) begin
        checks++;
        if (bus.stuck_zero !== 1'b1 || bus.locked !== 1'b0 || bus.err_pulse !== 1'b0) begin
          errors++;
          $display("FAIL stuck bit %0d got sz=%b lk=%b ep=%b want 1 0 0",
                   n, bus.stuck_zero, bus.locked, bus.err_pulse);
        end
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stuck_zero !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got sz=%b lk=%b want 0 0", bus.stuck_zero, bus.locked);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_stream();
    for (int n = 1; n <= 26; n++) begin
      send(1'b0, 1'b0);
      if (n == 25 || n == 26) begin
        checks++;
        if (bus.locked !== (n == 26)) begin
          errors++;
          $display("FAIL post_rst_lock bit %0d got %b want %b", n, bus.locked, (n == 26));
        end
      end
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    start_stream();
    lock_up("clear");
    for (int i = 0; i < 30; i++) begin
      send(i == 5, i == 5);
      if (i == 5) begin
        checks++;
        if (bus.err_count !== 16'd0 || bus.locked !== 1'b1) begin
          errors++;
          $display("FAIL clear_collide got ec=%0d lk=%b want 0 1", bus.err_count, bus.locked);
        end
      end
    end
    checks++;
    if (bus.err_count !== 16'd2) begin
      errors++;
      $display("FAIL clear_after got ec=%0d want 2", bus.err_count);
    end
  endtask

`ifdef PRBS_CHK_BITCNT_EN
  task automatic test_bit_count();
    do_reset();
    start_stream();
    lock_up("bitcnt");
    for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
    checks++;
    if (bus.bit_count !== 32'd100) begin
      errors++;
      $display("FAIL bit_count got %0d want 100", bus.bit_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_gapped_valid();
    test_stuck_zero();
    test_clear_collision();
`ifdef PRBS_CHK_BITCNT_EN
    test_bit_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
